// File: rtl/oam_sprite_evaluator_pkg.sv
// Shared OAM entry layout, screen constants and evaluator state encoding.
package madnes_sprite_pkg;

    localparam int OAM_ENTRIES   = 64;
    localparam int VISIBLE_LINES = 240;

    localparam int Y_MSB    = 31;
    localparam int Y_LSB    = 24;
    localparam int TILE_MSB = 23;
    localparam int TILE_LSB = 16;
    localparam int ATTR_MSB = 15;
    localparam int ATTR_LSB = 8;
    localparam int X_MSB    = 7;
    localparam int X_LSB    = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
    } oam_entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FINISH = 2'd2
    } eval_state_t;

endpackage

// File: rtl/oam_sprite_evaluator_if.sv
// Control, OAM read port and secondary-list read port of the sprite evaluator.
interface oam_sprite_evaluator_if;
    import madnes_sprite_pkg::*;

    // start is a one-cycle strobe honoured only while idle; done pulses for one
    // cycle when the list is valid, and busy is high for every scan cycle between.
    logic        start;
    logic [7:0]  next_line;
    logic [5:0]  oam_read_addr;
    logic [31:0] oam_read_data;
    logic        busy;
    logic        done;
    logic [3:0]  sprite_count;
    logic        overflow;
    logic [2:0]  sec_addr;
    logic [31:0] sec_data;
    logic [3:0]  sec_row;
    logic [5:0]  sec_index;
    eval_state_t state;

    modport slave (
        input  start, next_line, oam_read_data, sec_addr,
        output oam_read_addr, busy, done, sprite_count, overflow,
        output sec_data, sec_row, sec_index, state
    );

    modport master (
        output start, next_line, oam_read_data, sec_addr,
        input  oam_read_addr, busy, done, sprite_count, overflow,
        input  sec_data, sec_row, sec_index, state
    );

endinterface

// File: rtl/oam_sprite_evaluator_y_match.sv
// Combinational Y-range test: does a sprite at Y cover the given scanline, and at which row.
module oam_y_match #(
    parameter int SPRITE_HEIGHT = 8
) (
    input  logic [7:0] line_i,
    input  logic [7:0] y_i,
    output logic       match_o,
    output logic [3:0] row_o
);

    logic [8:0] diff;

    // 9-bit subtract: a borrow into bit 8 means the sprite starts below the line.
    assign diff    = {1'b0, line_i} - {1'b0, y_i};
    assign match_o = !diff[8] && (diff < 9'(SPRITE_HEIGHT));
    assign row_o   = match_o ? diff[3:0] : 4'd0;

endmodule

// File: rtl/oam_sprite_evaluator.sv
// Per-scanline OAM scan that collects up to MAX_SPRITES intersecting entries into a secondary list.
module oam_sprite_evaluator
    import madnes_sprite_pkg::*;
#(
    parameter int MAX_SPRITES   = 8,
    parameter int SPRITE_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    oam_sprite_evaluator_if.slave bus
);

    localparam int SW = $clog2(MAX_SPRITES);

    eval_state_t state_q, state_d;
    logic [7:0]  line_q, line_d;
    logic [5:0]  k_q, k_d;
    logic [3:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        wr_en;

    oam_entry_t  entry_q [MAX_SPRITES];
    logic [3:0]  row_q   [MAX_SPRITES];
    logic [5:0]  idx_q   [MAX_SPRITES];

    oam_entry_t  rd;
    logic        hit;
    logic [3:0]  hit_row;
    logic [SW-1:0] slot;

    assign rd   = oam_entry_t'(bus.oam_read_data);
    assign slot = count_q[SW-1:0];

    oam_y_match #(
        .SPRITE_HEIGHT(SPRITE_HEIGHT)
    ) u_y_match (
        .line_i  (line_q),
        .y_i     (rd.y),
        .match_o (hit),
        .row_o   (hit_row)
    );

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        k_d     = k_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    line_d  = bus.next_line;
                    count_d = 4'd0;
                    ovf_d   = 1'b0;
                    k_d     = 6'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                k_d = k_q + 6'd1;
                if (k_q == 6'(OAM_ENTRIES - 1)) begin
                    state_d = S_FINISH;
                end
                // A match with the list already full ends the scan early.
                if (hit) begin
                    if (count_q == 4'(MAX_SPRITES)) begin
                        ovf_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + 4'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            k_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                entry_q[i] <= '0;
                row_q[i]   <= '0;
                idx_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            k_q     <= k_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wr_en) begin
                entry_q[slot] <= rd;
                row_q[slot]   <= hit_row;
                idx_q[slot]   <= k_q;
            end
        end
    end

    assign bus.oam_read_addr = k_q;
    assign bus.busy          = (state_q == S_SCAN);
    assign bus.done          = (state_q == S_FINISH);
    assign bus.sprite_count  = count_q;
    assign bus.overflow      = ovf_q;
    assign bus.state         = state_q;

    // Slots at or beyond sprite_count hold whatever the last line left there.
    assign bus.sec_data  = entry_q[bus.sec_addr[SW-1:0]];
    assign bus.sec_row   = row_q[bus.sec_addr[SW-1:0]];
    assign bus.sec_index = idx_q[bus.sec_addr[SW-1:0]];

endmodule
